// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: WB control bit positions, register widths,
// and the MEM/WB latch entry layout.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Bit indices inside the 2-bit WB control field
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // One MEM/WB latch entry
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic [REG_AW-1:0] dst;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register with reset > flush > stall > capture priority.
module mem_wb_latch
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_mem_valid,
    input  logic [1:0]        ex_mem_wb,
    input  logic [DATA_W-1:0] ex_mem_alu_result,
    input  logic [REG_AW-1:0] ex_mem_write_reg,
    input  logic [DATA_W-1:0] mem_read_data,
    output mem_wb_t           entry
);

    // Capture the EX/MEM entry, hold it, or replace it with a bubble
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every field samples pre-edge values together.
        if (rst) begin
            entry <= '0;
        end else if (flush) begin
            entry <= '0;
        end else if (!stall) begin
            entry.valid    <= ex_mem_valid;
            entry.regwrite <= ex_mem_wb[WB_REGWRITE] & ex_mem_valid;
            entry.memtoreg <= ex_mem_wb[WB_MEMTOREG];
            entry.alu      <= ex_mem_alu_result;
            entry.rdata    <= mem_read_data;
            entry.dst      <= ex_mem_write_reg;
        end
    end

endmodule

// File: rtl/writeback.sv
// Write-back stage: MEM/WB latch, write-back data select, register-zero
// write suppression and retired-instruction counter.
module writeback
    import pipe_pkg::*;
#(
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_mem_valid,
    input  logic [1:0]        ex_mem_wb,
    input  logic [DATA_W-1:0] ex_mem_alu_result,
    input  logic [REG_AW-1:0] ex_mem_write_reg,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_write_reg_location,
    output logic [DATA_W-1:0] mem_wb_write_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retire_count
);

    mem_wb_t entry;
    logic    capture;

    mem_wb_latch u_latch (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_wb         (ex_mem_wb),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_write_reg  (ex_mem_write_reg),
        .mem_read_data     (mem_read_data),
        .entry             (entry)
    );

    // A real instruction enters MEM/WB only on a plain capture edge
    assign capture = !flush && !stall && ex_mem_valid;

    // Drive the register-file write port purely from latched state
    always_comb begin
        // NOTE: every output is assigned on every path, so no latch is inferred.
        wb_write_reg_location = entry.dst;
        wb_valid              = entry.valid;
        mem_wb_write_data     = entry.memtoreg ? entry.rdata : entry.alu;
        wb_reg_write          = entry.valid & entry.regwrite;
        if (ZERO_PROTECT && (entry.dst == REG_ZERO)) begin
            wb_reg_write = 1'b0;
        end
    end

    // Count retired instructions, wrapping at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (capture) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the write-back stage. A second instance
// with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_mem_valid;
    logic [1:0]  ex_mem_wb;
    logic [31:0] ex_mem_alu_result;
    logic [4:0]  ex_mem_write_reg;
    logic [31:0] mem_read_data;

    logic        wb_reg_write;
    logic [4:0]  wb_write_reg_location;
    logic [31:0] mem_wb_write_data;
    logic        wb_valid;
    logic [31:0] retire_count;

    logic        wb_reg_write4;
    logic [4:0]  wb_write_reg_location4;
    logic [31:0] mem_wb_write_data4;
    logic        wb_valid4;
    logic [3:0]  retire_count4;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    writeback dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall                 (stall),
        .flush                 (flush),
        .ex_mem_valid          (ex_mem_valid),
        .ex_mem_wb             (ex_mem_wb),
        .ex_mem_alu_result     (ex_mem_alu_result),
        .ex_mem_write_reg      (ex_mem_write_reg),
        .mem_read_data         (mem_read_data),
        .wb_reg_write          (wb_reg_write),
        .wb_write_reg_location (wb_write_reg_location),
        .mem_wb_write_data     (mem_wb_write_data),
        .wb_valid              (wb_valid),
        .retire_count          (retire_count)
    );

    writeback #(.ZERO_PROTECT(1'b1), .CNT_W(4)) dut4 (
        .clk                   (clk),
        .rst                   (rst),
        .stall                 (stall),
        .flush                 (flush),
        .ex_mem_valid          (ex_mem_valid),
        .ex_mem_wb             (ex_mem_wb),
        .ex_mem_alu_result     (ex_mem_alu_result),
        .ex_mem_write_reg      (ex_mem_write_reg),
        .mem_read_data         (mem_read_data),
        .wb_reg_write          (wb_reg_write4),
        .wb_write_reg_location (wb_write_reg_location4),
        .mem_wb_write_data     (mem_wb_write_data4),
        .wb_valid              (wb_valid4),
        .retire_count          (retire_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] dst);
        ex_mem_valid      = v;
        ex_mem_wb         = wb;
        ex_mem_alu_result = alu;
        mem_read_data     = rdata;
        ex_mem_write_reg  = dst;
    endtask

    // One rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] loc,
                             input logic [31:0] data, input logic v, input logic [31:0] cnt);
        check({tag, ".write"}, 32'(wb_reg_write), 32'(we));
        check({tag, ".loc"},   32'(wb_write_reg_location), 32'(loc));
        check({tag, ".data"},  mem_wb_write_data, data);
        check({tag, ".valid"}, 32'(wb_valid), 32'(v));
        check({tag, ".count"}, retire_count, cnt);
    endtask

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        #1 rst = 1'b1;
        #2;
        check_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        check("reset.count4", 32'(retire_count4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type: ALU result written to r9
        drive(1'b1, 2'b10, 32'h0000_0007, 32'hAAAA_5555, 5'd9);
        step();
        check_out("rtype", 1'b1, 5'd9, 32'h7, 1'b1, 32'd1);

        // Load: memory data selected, r4
        drive(1'b1, 2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 5'd4);
        step();
        check_out("load", 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 32'd2);

        // Write to r0 is suppressed but still retires
        drive(1'b1, 2'b10, 32'h0000_0005, 32'h0, 5'd0);
        step();
        check_out("zero", 1'b0, 5'd0, 32'h5, 1'b1, 32'd3);

        // Load an entry, then stall three cycles with different inputs
        drive(1'b1, 2'b10, 32'h0000_0055, 32'h1234_5678, 5'd12);
        step();
        check_out("pre_stall", 1'b1, 5'd12, 32'h55, 1'b1, 32'd4);
        stall = 1'b1;
        drive(1'b1, 2'b11, 32'h0000_0099, 32'hCAFE_F00D, 5'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("stall%0d", i), 1'b1, 5'd12, 32'h55, 1'b1, 32'd4);
        end

        // Stall and flush together: flush wins, no count
        flush = 1'b1;
        step();
        check_out("flush", 1'b0, 5'd0, 32'h0, 1'b0, 32'd4);
        stall = 1'b0;
        flush = 1'b0;

        // RegWrite set on a non-valid entry: no write, no count
        drive(1'b0, 2'b10, 32'h0000_0033, 32'h0, 5'd3);
        step();
        check_out("invalid", 1'b0, 5'd3, 32'h33, 1'b0, 32'd4);

        // Asynchronous reset in the middle of a held write
        drive(1'b1, 2'b10, 32'h0000_0011, 32'h0, 5'd5);
        step();
        check_out("pre_rst", 1'b1, 5'd5, 32'h11, 1'b1, 32'd5);
        #2 rst = 1'b1;
        #1;
        check_out("mid_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        check("mid_rst.count4", 32'(retire_count4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sixteen captures wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b10, 32'(i), 32'h0, 5'd1);
            step();
        end
        check("wrap.count4", 32'(retire_count4), 32'd0);
        check("wrap.count", retire_count, 32'd16);
        check("wrap.data", mem_wb_write_data, 32'd15);

        // Store: counted, no register write
        drive(1'b1, 2'b00, 32'h0000_0200, 32'h0, 5'd8);
        step();
        check_out("store", 1'b0, 5'd8, 32'h200, 1'b1, 32'd17);
        check("store.count4", 32'(retire_count4), 32'd1);
        check("store.write4", 32'(wb_reg_write4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
